// File: rtl/scaled_palette_blob.sv
// scaled_palette_blob: palette-indexed sprite with integer pixel replication.
// Three-cycle pipeline: region test/address gen -> ROM read -> palette/transparency.
module scaled_palette_blob #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned HEIGHT     = 64,
  parameter int unsigned IDX_BITS   = 8,
  parameter int unsigned ADDR_BITS  = 20,
  parameter int unsigned SCALE_LOG2 = 0,
  parameter int unsigned TRANSP_EN  = 1,
  parameter int unsigned TRANSP_IDX = 0
) (
  input  logic                 pixel_clk,
  input  logic                 reset_n,
  input  logic [10:0]          x,
  input  logic [10:0]          hcount,
  input  logic [9:0]           y,
  input  logic [9:0]           vcount,
  output logic [ADDR_BITS-1:0] image_addr,
  input  logic [IDX_BITS-1:0]  image_bits,
  input  logic                 pal_we,
  input  logic [IDX_BITS-1:0]  pal_waddr,
  input  logic [23:0]          pal_wdata,
  output logic [23:0]          pixel,
  output logic                 pixel_valid
);

  localparam int unsigned DW        = WIDTH << SCALE_LOG2;
  localparam int unsigned DH        = HEIGHT << SCALE_LOG2;
  localparam int unsigned PAL_DEPTH = 1 << IDX_BITS;
  localparam int unsigned SUB_W     = 3;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'((1 << SCALE_LOG2) - 1);

  logic                 in_frame, in_frame_nxt;
  logic [ADDR_BITS-1:0] line_base, line_base_nxt;
  logic [ADDR_BITS-1:0] col, col_nxt;
  logic [SUB_W-1:0]     col_sub, col_sub_nxt;
  logic [SUB_W-1:0]     row_sub, row_sub_nxt;
  logic [ADDR_BITS-1:0] addr_nxt;
  logic [1:0]           valid_pipe;

  logic [11:0] h12, v12, x12, y12, x_end, y_end;
  logic        in_region_c, frame_start_c, last_col_c, last_row_c, active_c;
  logic        transp_c;
  logic [23:0] pal_rd_c;

  logic [23:0] pal_mem [PAL_DEPTH];

  // Region test in 12 bits so the right/bottom edge never wraps
  always_comb begin
    h12           = 12'(hcount);
    v12           = 12'(vcount);
    x12           = 12'(x);
    y12           = 12'(y);
    x_end         = x12 + 12'(DW);
    y_end         = y12 + 12'(DH);
    in_region_c   = (h12 >= x12) && (h12 < x_end) && (v12 >= y12) && (v12 < y_end);
    frame_start_c = (hcount == x) && (vcount == y);
    last_col_c    = (h12 == x_end - 12'd1);
    last_row_c    = (v12 == y_end - 12'd1);
    active_c      = in_region_c && (in_frame || frame_start_c);
  end

  // Incremental address generator; a frame start zeroes the counters before use
  always_comb begin
    in_frame_nxt  = frame_start_c ? 1'b1 : in_frame;
    line_base_nxt = frame_start_c ? '0 : line_base;
    col_nxt       = frame_start_c ? '0 : col;
    col_sub_nxt   = frame_start_c ? '0 : col_sub;
    row_sub_nxt   = frame_start_c ? '0 : row_sub;
    addr_nxt      = image_addr;
    if (active_c) begin
      addr_nxt = line_base_nxt + col_nxt;
      if (last_col_c) begin
        col_nxt     = '0;
        col_sub_nxt = '0;
        if (row_sub_nxt == SUB_MAX) begin
          row_sub_nxt   = '0;
          line_base_nxt = line_base_nxt + ADDR_BITS'(WIDTH);
        end else begin
          row_sub_nxt = row_sub_nxt + SUB_W'(1);
        end
        if (last_row_c) begin
          in_frame_nxt = 1'b0;
        end
      end else if (col_sub_nxt == SUB_MAX) begin
        col_sub_nxt = '0;
        col_nxt     = col_nxt + ADDR_BITS'(1);
      end else begin
        col_sub_nxt = col_sub_nxt + SUB_W'(1);
      end
    end
  end

  // Stage 0/1 registers: counters, ROM address and the in-region valid pipe
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      in_frame   <= 1'b0;
      line_base  <= '0;
      col        <= '0;
      col_sub    <= '0;
      row_sub    <= '0;
      image_addr <= '0;
      valid_pipe <= '0;
    end else begin
      in_frame   <= in_frame_nxt;
      line_base  <= line_base_nxt;
      col        <= col_nxt;
      col_sub    <= col_sub_nxt;
      row_sub    <= row_sub_nxt;
      image_addr <= addr_nxt;
      valid_pipe <= {valid_pipe[0], active_c};
    end
  end

  // Palette storage; read-first falls out of the registered read below
  always_ff @(posedge pixel_clk) begin
    if (pal_we) begin
      pal_mem[pal_waddr] <= pal_wdata;
    end
  end

  // Stage 2 lookup and transparency test
  always_comb begin
    pal_rd_c = pal_mem[image_bits];
    transp_c = (TRANSP_EN != 0) && (image_bits == IDX_BITS'(TRANSP_IDX));
  end

  // Output register: third valid stage gated by transparency
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel       <= '0;
      pixel_valid <= 1'b0;
    end else if (valid_pipe[1] && !transp_c) begin
      pixel       <= pal_rd_c;
      pixel_valid <= 1'b1;
    end else begin
      pixel       <= '0;
      pixel_valid <= 1'b0;
    end
  end

endmodule
